// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with core port, host request/ack port and done flag
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   addr, wdata, wm_en  : core byte address, store data, write enable
//   rd_mem              : core read data, combinational
//   host_req, host_we   : host request, write(1)/read(0)
//   host_addr/wdata     : host byte address, write data
//   host_ack/rdata/err  : one-cycle completion pulse, read data (held), address-error flag
//   done                : done-flag register
module dmem_responder #(
  parameter int N = 32,
  parameter int DEPTH = 256,
  parameter logic [N-1:0] DONE_ADDR = N'(32'h0000_0400)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  input  logic         wm_en,
  output logic [N-1:0] rd_mem,
  input  logic         host_req,
  input  logic         host_we,
  input  logic [N-1:0] host_addr,
  input  logic [N-1:0] host_wdata,
  output logic         host_ack,
  output logic [N-1:0] host_rdata,
  output logic         host_err,
  output logic         done
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [N-1:0] RAM_BYTES = N'(DEPTH * 4);
  typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;
  logic [N-1:0] mem [DEPTH];
  state_t state_q, state_d;
  logic hwe_q, hwe_d, ack_q, ack_d, err_q, err_d, done_q, done_d, h_wr;
  logic [N-1:0] haddr_q, haddr_d, hwdata_q, hwdata_d, rdata_q, rdata_d, h_rd;
  logic c_ram, c_done, h_ram, h_done, serve;
  assign c_ram  = addr < RAM_BYTES;
  assign c_done = addr == DONE_ADDR;
  assign h_ram  = haddr_q < RAM_BYTES;
  assign h_done = haddr_q == DONE_ADDR;
  assign rd_mem = c_ram ? mem[addr[AW+1:2]] : c_done ? {{(N-1){1'b0}}, done_q} : '0;
  assign h_rd   = h_ram ? mem[haddr_q[AW+1:2]] : {{(N-1){1'b0}}, done_q};
  // host access only proceeds in a cycle the core is not writing
  assign serve  = state_q == SERVE && !wm_en;
  assign host_ack = ack_q;
  assign host_rdata = rdata_q;
  assign host_err = err_q;
  assign done = done_q;
  always_comb begin
    state_d  = state_q;
    hwe_d    = hwe_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    done_d   = done_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    h_wr     = 1'b0;
    if (state_q == IDLE && host_req) begin
      state_d  = SERVE;
      hwe_d    = host_we;
      haddr_d  = host_addr;
      hwdata_d = host_wdata;
    end
    if (serve) begin
      state_d = RESP;
      ack_d   = 1'b1;
      err_d   = !(h_ram || h_done);
      h_wr    = hwe_q && h_ram && !reset;
      done_d  = hwe_q && h_done ? hwdata_q[0] : done_q;
      rdata_d = !hwe_q && (h_ram || h_done) ? h_rd : rdata_q;
    end
    if (state_q == RESP) state_d = IDLE;
    if (wm_en && c_done) done_d = wdata[0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      hwe_q    <= 1'b0;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      hwe_q    <= hwe_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end
  always_ff @(posedge clock) begin
    if (wm_en && c_ram) mem[addr[AW+1:2]] <= wdata;
    else if (h_wr) mem[haddr_q[AW+1:2]] <= hwdata_q;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  logic clock = 1'b0, reset = 1'b1, wm_en = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, host_addr = '0, host_wdata = '0;
  logic [31:0] rd_mem, host_rdata;
  logic host_ack, host_err, done;
  int errors = 0, checks = 0, lat;
  dmem_responder dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .wm_en(wm_en),
    .rd_mem(rd_mem), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_err(host_err), .done(done)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic host_txn(input logic we, input logic [31:0] a, input logic [31:0] d, output int l);
    host_req = 1'b1;
    host_we = we;
    host_addr = a;
    host_wdata = d;
    @(posedge clock); #1 host_req = 1'b0;
    l = 1;
    while (!host_ack && l < 20) begin
      @(posedge clock); #1 l++;
    end
  endtask
  task automatic core_store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdata = d;
    wm_en = 1'b1;
    @(posedge clock); #1 wm_en = 1'b0;
  endtask
  task automatic ack_gone(input string tag);
    @(posedge clock); #1 check(tag, {31'b0, host_ack}, 32'd0);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_ack", {31'b0, host_ack}, 32'd0);
    check("rst_rdata", host_rdata, 32'd0);
    check("rst_err", {31'b0, host_err}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    host_txn(1'b1, 32'h10, 32'hDEADBEEF, lat);
    check("wr_lat", lat, 32'd2);
    check("wr_err", {31'b0, host_err}, 32'd0);
    ack_gone("wr_ack_width");
    host_txn(1'b0, 32'h10, 32'h0, lat);
    check("rd_lat", lat, 32'd2);
    check("rd_data", host_rdata, 32'hDEADBEEF);
    ack_gone("rd_ack_width");
    check("rd_hold", host_rdata, 32'hDEADBEEF);
    addr = 32'h10;
    #1 check("core_rd_10", rd_mem, 32'hDEADBEEF);
    core_store(32'h20, 32'h12345678);
    check("core_rd_20", rd_mem, 32'h12345678);
    host_txn(1'b1, 32'h30, 32'h11111111, lat);
    @(posedge clock); #1;
    fork
      host_txn(1'b0, 32'h30, 32'h0, lat);
      begin
        @(posedge clock); #1;
        addr = 32'h30;
        wdata = 32'hA5A5A5A5;
        wm_en = 1'b1;
        repeat (3) @(posedge clock);
        #1 wm_en = 1'b0;
      end
    join
    check("stall_lat", lat, 32'd5);
    check("stall_data", host_rdata, 32'hA5A5A5A5);
    @(posedge clock); #1;
    core_store(32'h400, 32'h1);
    check("done_set", {31'b0, done}, 32'd1);
    check("core_rd_done", rd_mem, 32'h1);
    addr = 32'h401;
    #1 check("core_rd_401", rd_mem, 32'h0);
    host_txn(1'b0, 32'h400, 32'h0, lat);
    check("host_rd_done", host_rdata, 32'h1);
    check("host_rd_done_err", {31'b0, host_err}, 32'd0);
    @(posedge clock); #1;
    host_txn(1'b1, 32'h400, 32'h0, lat);
    check("host_clr_done", {31'b0, done}, 32'd0);
    @(posedge clock); #1;
    host_txn(1'b1, 32'h0, 32'hCAFEF00D, lat);
    @(posedge clock); #1;
    host_txn(1'b0, 32'h800, 32'h0, lat);
    check("miss_lat", lat, 32'd2);
    check("miss_err", {31'b0, host_err}, 32'd1);
    check("miss_rdata", host_rdata, 32'h1);
    @(posedge clock); #1 check("miss_err_clr", {31'b0, host_err}, 32'd0);
    host_txn(1'b1, 32'h404, 32'h1, lat);
    check("miss_wr_err", {31'b0, host_err}, 32'd1);
    check("miss_wr_done", {31'b0, done}, 32'd0);
    @(posedge clock); #1;
    addr = 32'h800;
    #1 check("core_rd_800", rd_mem, 32'h0);
    core_store(32'h800, 32'hFFFFFFFF);
    addr = 32'h0;
    #1 check("core_miss_alias", rd_mem, 32'hCAFEF00D);
    check("core_miss_done", {31'b0, done}, 32'd0);
    core_store(32'h400, 32'h1);
    host_req = 1'b1;
    host_we = 1'b1;
    host_addr = 32'h10;
    host_wdata = 32'h55555555;
    @(posedge clock); #1;
    host_req = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_serve_ack", {31'b0, host_ack}, 32'd0);
    ack_gone("rst_serve_ack2");
    addr = 32'h10;
    #1 check("rst_serve_word", rd_mem, 32'hDEADBEEF);
    check("rst_serve_done", {31'b0, done}, 32'd0);
    host_txn(1'b0, 32'h20, 32'h0, lat);
    check("post_rst_lat", lat, 32'd2);
    check("post_rst_data", host_rdata, 32'h12345678);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
